// File: rtl/alu_issue_arbiter.sv
// alu_issue_arbiter
// Lets two requesters share one combinational RV32I ALU. Req 0 is the
// integer pipe and req 1 is the address/branch unit. The block picks a
// requester round-robin, decodes the 11-bit funct code
// {funct7[5], funct3, opcode} into a 4-bit ALU control, drives the
// registered operands for one EXEC cycle, captures the result and returns
// it with a requester tag. Only one operation is in flight at a time.
//
// Handshakes use strict valid/ready: a transfer happens on a rising clock
// edge where valid and ready are both high. The sender must hold valid and
// its payload stable until that edge. Ready may depend combinationally on
// valid.
//
// Optional build macro ALU_ISSUE_PERF_EN adds saturating performance
// counters: grant_cnt_0, grant_cnt_1 and illegal_cnt.
//
// dbg_state_o exposes the sequencer state (0 IDLE, 1 EXEC, 2 RESP).

module alu_issue_arbiter #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid_0,
    output logic            req_ready_0,
    input  logic [10:0]     req_funct_0,
    input  logic [XLEN-1:0] req_a_0,
    input  logic [XLEN-1:0] req_b_0,
    input  logic            req_valid_1,
    output logic            req_ready_1,
    input  logic [10:0]     req_funct_1,
    input  logic [XLEN-1:0] req_a_1,
    input  logic [XLEN-1:0] req_b_1,
    output logic [3:0]      alu_ctrl,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic            alu_valid,
    input  logic [XLEN-1:0] alu_result,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [XLEN-1:0] rsp_result,
    output logic            rsp_illegal,
    output logic [1:0]      dbg_state_o
`ifdef ALU_ISSUE_PERF_EN
    ,
    output logic [CNT_W-1:0] grant_cnt_0,
    output logic [CNT_W-1:0] grant_cnt_1,
    output logic [CNT_W-1:0] illegal_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_e;

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;

    // Counters need at least one bit to be meaningful.
    if (CNT_W < 1) begin : g_cnt_w_check
        $error("alu_issue_arbiter: CNT_W must be at least 1");
    end

    state_e          state_q;
    logic            last_grant_q;
    logic [3:0]      alu_ctrl_q;
    logic [XLEN-1:0] alu_a_q;
    logic [XLEN-1:0] alu_b_q;
    logic            alu_valid_q;
    logic            illegal_q;
    logic            id_q;
    logic            rsp_valid_q;
    logic            rsp_id_q;
    logic [XLEN-1:0] rsp_result_q;
    logic            rsp_illegal_q;

    logic            in_idle;
    logic            grant_id;
    logic            grant_hs;
    logic [10:0]     sel_funct;
    logic [XLEN-1:0] sel_a;
    logic [XLEN-1:0] sel_b;
    logic            f7;
    logic [2:0]      f3;
    logic [6:0]      op;
    logic [3:0]      dec_ctrl;
    logic            dec_illegal;

    // Round-robin pick. On a tie the requester that did not win last time
    // gets the grant. Ready is held low during reset.
    always_comb begin
        in_idle     = (state_q == S_IDLE) && rst_n;
        grant_id    = (req_valid_0 && req_valid_1) ? ~last_grant_q : req_valid_1;
        req_ready_0 = in_idle && req_valid_0 && !grant_id;
        req_ready_1 = in_idle && req_valid_1 && grant_id;
        grant_hs    = (req_valid_0 && req_ready_0) || (req_valid_1 && req_ready_1);
        sel_funct   = grant_id ? req_funct_1 : req_funct_0;
        sel_a       = grant_id ? req_a_1 : req_a_0;
        sel_b       = grant_id ? req_b_1 : req_b_0;
    end

    // Decode the granted funct code into ALU control. Unsupported codes are
    // flagged illegal and drive control 0000.
    always_comb begin
        f7          = sel_funct[10];
        f3          = sel_funct[9:7];
        op          = sel_funct[6:0];
        dec_ctrl    = 4'b0000;
        dec_illegal = 1'b1;
        case (op)
            OP_R: begin
                if (!f7) begin
                    dec_ctrl    = {1'b0, f3};
                    dec_illegal = 1'b0;
                end else if (f3 == 3'b000) begin
                    dec_ctrl    = 4'b1000;
                    dec_illegal = 1'b0;
                end else if (f3 == 3'b101) begin
                    dec_ctrl    = 4'b1101;
                    dec_illegal = 1'b0;
                end
            end
            OP_I: begin
                if (f3 == 3'b001) begin
                    // SLLI with funct7[5] set has no RV32I meaning.
                    if (!f7) begin
                        dec_ctrl    = 4'b0001;
                        dec_illegal = 1'b0;
                    end
                end else if (f3 == 3'b101) begin
                    // funct7[5] selects SRAI over SRLI.
                    dec_ctrl    = {f7, 3'b101};
                    dec_illegal = 1'b0;
                end else begin
                    // The immediate occupies funct7 here, so the bit is ignored.
                    dec_ctrl    = {1'b0, f3};
                    dec_illegal = 1'b0;
                end
            end
            default: begin
                dec_ctrl    = 4'b0000;
                dec_illegal = 1'b1;
            end
        endcase
    end

    // Sequencer IDLE -> EXEC -> RESP -> IDLE, with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            last_grant_q  <= 1'b1;
            alu_ctrl_q    <= 4'b0000;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_valid_q   <= 1'b0;
            illegal_q     <= 1'b0;
            id_q          <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= 1'b0;
            rsp_result_q  <= '0;
            rsp_illegal_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (grant_hs) begin
                        // Illegal ops present zeroed operands to the ALU.
                        alu_ctrl_q   <= dec_ctrl;
                        alu_a_q      <= dec_illegal ? '0 : sel_a;
                        alu_b_q      <= dec_illegal ? '0 : sel_b;
                        alu_valid_q  <= 1'b1;
                        illegal_q    <= dec_illegal;
                        id_q         <= grant_id;
                        last_grant_q <= grant_id;
                        state_q      <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    rsp_result_q  <= illegal_q ? '0 : alu_result;
                    rsp_id_q      <= id_q;
                    rsp_illegal_q <= illegal_q;
                    rsp_valid_q   <= 1'b1;
                    alu_valid_q   <= 1'b0;
                    state_q       <= S_RESP;
                end
                S_RESP: begin
                    // No new grant in this cycle; IDLE takes the next one.
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign alu_ctrl    = alu_ctrl_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_valid   = alu_valid_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_result  = rsp_result_q;
    assign rsp_illegal = rsp_illegal_q;
    assign dbg_state_o = state_q;

`ifdef ALU_ISSUE_PERF_EN
    logic [CNT_W-1:0] grant_cnt_0_q;
    logic [CNT_W-1:0] grant_cnt_1_q;
    logic [CNT_W-1:0] illegal_cnt_q;

    // Saturating counts of grants per requester and of accepted illegal ops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt_0_q <= '0;
            grant_cnt_1_q <= '0;
            illegal_cnt_q <= '0;
        end else begin
            if (req_valid_0 && req_ready_0 && (grant_cnt_0_q != '1)) begin
                grant_cnt_0_q <= grant_cnt_0_q + CNT_W'(1);
            end
            if (req_valid_1 && req_ready_1 && (grant_cnt_1_q != '1)) begin
                grant_cnt_1_q <= grant_cnt_1_q + CNT_W'(1);
            end
            if (grant_hs && dec_illegal && (illegal_cnt_q != '1)) begin
                illegal_cnt_q <= illegal_cnt_q + CNT_W'(1);
            end
        end
    end

    assign grant_cnt_0 = grant_cnt_0_q;
    assign grant_cnt_1 = grant_cnt_1_q;
    assign illegal_cnt = illegal_cnt_q;
`endif

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Testbench for alu_issue_arbiter: a combinational ALU model as the
// datapath, an instruction-level reference model and an expected-response
// queue.
module tb_alu_issue_arbiter;
  localparam int XLEN = 32;
  localparam int TB_CNT_W = 4;

  localparam logic [10:0] F_ADD      = 11'b0_000_0110011;
  localparam logic [10:0] F_SUB      = 11'b1_000_0110011;
  localparam logic [10:0] F_SRAI     = 11'b1_101_0010011;
  localparam logic [10:0] F_SLLI_BAD = 11'b1_001_0010011;
  localparam logic [10:0] F_SLTIU    = 11'b0_011_0010011;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_valid_0 = 0, req_valid_1 = 0, rsp_ready = 0;
  logic [10:0] req_funct_0 = '0, req_funct_1 = '0;
  logic [XLEN-1:0] req_a_0 = '0, req_b_0 = '0, req_a_1 = '0, req_b_1 = '0;
  logic req_ready_0, req_ready_1, alu_valid, rsp_valid, rsp_id, rsp_illegal;
  logic [3:0] alu_ctrl;
  logic [XLEN-1:0] alu_a, alu_b, alu_result, rsp_result;
  logic [1:0] dbg_state;
`ifdef ALU_ISSUE_PERF_EN
  logic [TB_CNT_W-1:0] grant_cnt_0, grant_cnt_1, illegal_cnt;
`endif

  int checks = 0;
  int failures = 0;
  int m_last = 1;
  logic [XLEN+1:0] exp_q[$];

  // clock / reset block
  always #5 clk = ~clk;

  alu_issue_arbiter #(.XLEN(XLEN), .CNT_W(TB_CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_0(req_valid_0), .req_ready_0(req_ready_0), .req_funct_0(req_funct_0),
    .req_a_0(req_a_0), .req_b_0(req_b_0),
    .req_valid_1(req_valid_1), .req_ready_1(req_ready_1), .req_funct_1(req_funct_1),
    .req_a_1(req_a_1), .req_b_1(req_b_1),
    .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b), .alu_valid(alu_valid),
    .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_illegal(rsp_illegal),
    .dbg_state_o(dbg_state)
`ifdef ALU_ISSUE_PERF_EN
    , .grant_cnt_0(grant_cnt_0), .grant_cnt_1(grant_cnt_1), .illegal_cnt(illegal_cnt)
`endif
  );

  // The shared datapath ALU that the arbiter drives.
  always_comb begin
    case (alu_ctrl)
      4'b0000: alu_result = alu_a + alu_b;
      4'b0001: alu_result = alu_a << alu_b[4:0];
      4'b0010: alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
      4'b0011: alu_result = {31'd0, alu_a < alu_b};
      4'b0100: alu_result = alu_a ^ alu_b;
      4'b0101: alu_result = alu_a >> alu_b[4:0];
      4'b0110: alu_result = alu_a | alu_b;
      4'b0111: alu_result = alu_a & alu_b;
      4'b1000: alu_result = alu_a - alu_b;
      4'b1101: alu_result = $signed(alu_a) >>> alu_b[4:0];
      default: alu_result = 32'hdead_beef;
    endcase
  end

  function automatic string base_name(input logic [2:0] f3);
    case (f3)
      3'd0: return "add";
      3'd1: return "sll";
      3'd2: return "slt";
      3'd3: return "sltu";
      3'd4: return "xor";
      3'd5: return "srl";
      3'd6: return "or";
      default: return "and";
    endcase
  endfunction

  // Reference model at the instruction level: name the RV32I operation, then
  // compute its result and its documented control encoding.
  function automatic void ref_op(input logic [10:0] f, input logic [31:0] a, b,
                                 output logic ill, output logic [3:0] ctrl,
                                 output logic [31:0] res);
    string mn;
    mn = "illegal";
    if (f[6:0] == 7'b0110011) begin
      if (!f[10]) mn = base_name(f[9:7]);
      else if (f[9:7] == 3'd0) mn = "sub";
      else if (f[9:7] == 3'd5) mn = "sra";
    end else if (f[6:0] == 7'b0010011) begin
      if (f[9:7] == 3'd1) mn = f[10] ? "illegal" : "sll";
      else if (f[9:7] == 3'd5) mn = f[10] ? "sra" : "srl";
      else mn = base_name(f[9:7]);
    end
    ill = 1'b0;
    case (mn)
      "add":  begin ctrl = 4'b0000; res = a + b; end
      "sll":  begin ctrl = 4'b0001; res = a << b[4:0]; end
      "slt":  begin ctrl = 4'b0010; res = ($signed(a) < $signed(b)) ? 1 : 0; end
      "sltu": begin ctrl = 4'b0011; res = (a < b) ? 1 : 0; end
      "xor":  begin ctrl = 4'b0100; res = a ^ b; end
      "srl":  begin ctrl = 4'b0101; res = a >> b[4:0]; end
      "or":   begin ctrl = 4'b0110; res = a | b; end
      "and":  begin ctrl = 4'b0111; res = a & b; end
      "sub":  begin ctrl = 4'b1000; res = a - b; end
      "sra":  begin ctrl = 4'b1101; res = $signed(a) >>> b[4:0]; end
      default: begin ill = 1'b1; ctrl = 4'b0000; res = '0; end
    endcase
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid_0 = 0; req_valid_1 = 0; rsp_ready = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    m_last = 1;
    exp_q.delete();
    #1;
  endtask

  // Driver: present one or two requests, follow the granted operation
  // through EXEC and RESP, stall the response, then complete it.
  task automatic run_txn(input bit v0, input bit v1, input logic [10:0] f0, input logic [10:0] f1,
                         input logic [31:0] a0, input logic [31:0] b0,
                         input logic [31:0] a1, input logic [31:0] b1,
                         input int stall, output int gid);
    logic e_ill;
    logic [3:0] e_ctrl;
    logic [31:0] e_res, e_a, e_b;
    logic [XLEN+1:0] e;
    int eg, waited;
    req_valid_0 = v0; req_funct_0 = f0; req_a_0 = a0; req_b_0 = b0;
    req_valid_1 = v1; req_funct_1 = f1; req_a_1 = a1; req_b_1 = b1;
    rsp_ready = 0;
    gid = -1;
    eg = (v0 && v1) ? 1 - m_last : (v1 ? 1 : 0);
    waited = 0;
    #1;
    while (!(req_ready_0 || req_ready_1) && waited < 5) begin
      @(posedge clk); #2; waited++;
    end
    checks++;
    if (!(req_ready_0 || req_ready_1)) begin
      failures++; $display("FAIL grant_timeout: no req_ready within 5 cycles");
      req_valid_0 = 0; req_valid_1 = 0;
      return;
    end
    gid = req_ready_1 ? 1 : 0;
    checks++;
    if ({req_ready_1, req_ready_0} !== ((eg == 1) ? 2'b10 : 2'b01)) begin
      failures++; $display("FAIL grant: ready=%b expected requester %0d", {req_ready_1, req_ready_0}, eg);
    end
    if (eg == 1) begin e_a = a1; e_b = b1; ref_op(f1, a1, b1, e_ill, e_ctrl, e_res); end
    else begin e_a = a0; e_b = b0; ref_op(f0, a0, b0, e_ill, e_ctrl, e_res); end
    if (e_ill) begin e_a = '0; e_b = '0; end
    m_last = eg;
    exp_q.push_back({e_ill, eg[0], e_res});

    // EXEC cycle
    @(posedge clk); #1;
    checks++;
    if ({alu_valid, alu_ctrl, alu_a, alu_b} !== {1'b1, e_ctrl, e_a, e_b}) begin
      failures++; $display("FAIL exec: valid=%b ctrl=%b a=%h b=%h expected 1 %b %h %h",
                           alu_valid, alu_ctrl, alu_a, alu_b, e_ctrl, e_a, e_b);
    end
    checks++;
    if ({rsp_valid, req_ready_0, req_ready_1} !== 3'b000) begin
      failures++; $display("FAIL exec_quiet: rsp_valid=%b ready=%b%b expected 000", rsp_valid, req_ready_0, req_ready_1);
    end
    req_valid_0 = 0; req_valid_1 = 0;

    // RESP: response appears two cycles after the handshake cycle
    @(posedge clk); #1;
    e = exp_q.pop_front();
    checks++;
    if ({rsp_valid, rsp_illegal, rsp_id, rsp_result} !== {1'b1, e}) begin
      failures++; $display("FAIL resp: valid=%b ill=%b id=%b res=%h expected 1 %b %b %h",
                           rsp_valid, rsp_illegal, rsp_id, rsp_result, e[XLEN+1], e[XLEN], e[XLEN-1:0]);
    end
    checks++;
    if ({alu_valid, alu_ctrl} !== {1'b0, e_ctrl}) begin
      failures++; $display("FAIL alu_hold: valid=%b ctrl=%b expected 0 %b", alu_valid, alu_ctrl, e_ctrl);
    end
    for (int s = 0; s < stall; s++) begin
      req_valid_0 = 1; req_valid_1 = 1;
      @(posedge clk); #1;
      checks++;
      if ({rsp_valid, rsp_illegal, rsp_id, rsp_result, req_ready_0, req_ready_1} !== {1'b1, e, 2'b00}) begin
        failures++; $display("FAIL stall: valid=%b res=%h ready=%b%b expected held response, no ready",
                             rsp_valid, rsp_result, req_ready_0, req_ready_1);
      end
    end
    rsp_ready = 1; req_valid_0 = 1; req_valid_1 = 1;
    #1;
    checks++;
    if ({req_ready_0, req_ready_1} !== 2'b00) begin
      failures++; $display("FAIL resp_no_grant: ready=%b%b expected 00", req_ready_0, req_ready_1);
    end
    @(posedge clk); #1;
    rsp_ready = 0; req_valid_0 = 0; req_valid_1 = 0;
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++; $display("FAIL resp_drop: rsp_valid=%b expected 0", rsp_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 0; req_valid_0 = 1; req_valid_1 = 1; rsp_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({alu_valid, alu_ctrl, alu_a, alu_b, rsp_valid, rsp_id, rsp_illegal, rsp_result,
         req_ready_0, req_ready_1} !== '0) begin
      failures++; $display("FAIL reset_outputs: ctrl=%b a=%h b=%h rsp_valid=%b ready=%b%b expected all 0",
                           alu_ctrl, alu_a, alu_b, rsp_valid, req_ready_0, req_ready_1);
    end
    req_valid_0 = 0; req_valid_1 = 0;
    rst_n = 1; m_last = 1;
    #1;
    checks++;
    if ({rsp_valid, alu_valid, req_ready_0, req_ready_1} !== 4'b0000) begin
      failures++; $display("FAIL reset_release: rsp_valid=%b alu_valid=%b ready=%b%b expected 0",
                           rsp_valid, alu_valid, req_ready_0, req_ready_1);
    end
  endtask

  task automatic test_add();
    int g;
    run_txn(1, 0, F_ADD, '0, 32'd5, 32'd7, '0, '0, 0, g);
    checks++;
    if (g !== 0) begin failures++; $display("FAIL add_grant: got %0d expected 0", g); end
  endtask

  task automatic test_tie();
    int g;
    do_reset();
    run_txn(1, 1, F_SUB, F_SRAI, 32'd100, 32'd30, 32'h8000_0010, 32'd4, 0, g);
    checks++;
    if (g !== 0) begin failures++; $display("FAIL tie_first: got %0d expected 0", g); end
    run_txn(0, 1, F_SUB, F_SRAI, 32'd100, 32'd30, 32'h8000_0010, 32'd4, 0, g);
    checks++;
    if (g !== 1) begin failures++; $display("FAIL tie_second: got %0d expected 1", g); end
    run_txn(1, 1, F_SUB, F_SRAI, 32'd9, 32'd10, 32'd1, 32'd1, 0, g);
    checks++;
    if (g !== 0) begin failures++; $display("FAIL tie_rewin: got %0d expected 0", g); end
  endtask

  task automatic test_illegal();
    int g;
    run_txn(0, 1, F_ADD, F_SLLI_BAD, '0, '0, 32'h1234_5678, 32'd3, 0, g);
    run_txn(1, 0, 11'b0_000_1100011, '0, 32'd7, 32'd8, '0, '0, 0, g);
    run_txn(1, 0, F_SLTIU, '0, 32'd3, 32'hffff_fff0, '0, '0, 0, g);
  endtask

  task automatic test_stall();
    int g;
    run_txn(1, 0, F_ADD, '0, 32'hffff_ffff, 32'd2, '0, '0, 5, g);
  endtask

  task automatic test_reset_mid();
    int g;
    req_valid_0 = 1; req_funct_0 = F_ADD; req_a_0 = 32'd11; req_b_0 = 32'd22;
    #1;
    @(posedge clk); #1;
    checks++;
    if (alu_valid !== 1'b1) begin failures++; $display("FAIL mid_exec: alu_valid=%b expected 1", alu_valid); end
    rst_n = 0;
    #1;
    checks++;
    if ({alu_valid, alu_ctrl, alu_a, alu_b, rsp_valid, rsp_id, rsp_illegal, rsp_result,
         req_ready_0, req_ready_1} !== '0) begin
      failures++; $display("FAIL mid_reset_outputs: alu_a=%h rsp_valid=%b ready=%b%b expected all 0",
                           alu_a, rsp_valid, req_ready_0, req_ready_1);
    end
    req_valid_0 = 0;
    @(posedge clk); #1;
    rst_n = 1; m_last = 1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b0) begin failures++; $display("FAIL mid_no_resp: rsp_valid=%b expected 0", rsp_valid); end
    end
    run_txn(1, 1, F_ADD, F_SUB, 32'd1, 32'd2, 32'd3, 32'd4, 0, g);
    checks++;
    if (g !== 0) begin failures++; $display("FAIL mid_fresh_grant: got %0d expected 0", g); end
  endtask

  function automatic logic [10:0] rand_funct();
    logic [6:0] op;
    case ($urandom_range(0, 3))
      0, 1: op = 7'b0110011;
      2: op = 7'b0010011;
      default: op = 7'($urandom);
    endcase
    return {1'($urandom), 3'($urandom), op};
  endfunction

  task automatic test_random();
    int g;
    logic [1:0] v;
    for (int i = 0; i < 40; i++) begin
      v = 2'($urandom_range(1, 3));
      run_txn(v[0], v[1], rand_funct(), rand_funct(), $urandom, $urandom, $urandom, $urandom,
              $urandom_range(0, 3), g);
    end
  endtask

`ifdef ALU_ISSUE_PERF_EN
  task automatic test_perf();
    int g;
    int n_ill;
    do_reset();
    n_ill = 0;
    for (int i = 0; i < 17; i++) begin
      if (i % 4 == 0) n_ill++;
      run_txn(1, 0, (i % 4 == 0) ? F_SLLI_BAD : F_ADD, '0, 32'(i), 32'd1, '0, '0, 0, g);
    end
    checks++;
    if (grant_cnt_0 !== 4'(15)) begin failures++; $display("FAIL perf_grant0: got %0d expected 15", grant_cnt_0); end
    checks++;
    if (grant_cnt_1 !== 4'(0)) begin failures++; $display("FAIL perf_grant1: got %0d expected 0", grant_cnt_1); end
    checks++;
    if (illegal_cnt !== 4'(n_ill)) begin failures++; $display("FAIL perf_illegal: got %0d expected %0d", illegal_cnt, n_ill); end
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_tie();
    test_illegal();
    test_stall();
    test_reset_mid();
    test_random();
`ifdef ALU_ISSUE_PERF_EN
    test_perf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_issue_arbiter.md
Name: alu_issue_arbiter

Overview:
- Shares the single combinational RV32I ALU between two requesters (req 0 = integer pipe, req 1 = address/branch unit).
- Arbitrates round-robin and decodes each granted 11-bit funct code {funct7[5], funct3, opcode} into the 4-bit ALU control.
- Registers the operands onto the ALU, captures the result and returns it on one shared response channel with a requester tag.
- Three-state sequencer; one operation in flight at a time.

Parameters:
XLEN, 32, operand/result width
CNT_W, 16, width of performance counters (optional feature only)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid_0  in  1  requester 0 has an operation
req_ready_0  out  1  requester 0 accepted this cycle
req_funct_0  in  11  {funct7[5], funct3[2:0], opcode[6:0]}
req_a_0  in  XLEN  operand A (rs1)
req_b_0  in  XLEN  operand B (rs2 or sign-extended immediate)
req_valid_1, req_ready_1, req_funct_1, req_a_1, req_b_1  same as requester 0
alu_ctrl  out  4  ALU control to datapath
alu_a  out  XLEN  ALU operand A
alu_b  out  XLEN  ALU operand B
alu_valid  out  1  ALU inputs valid (EXEC state)
alu_result  in  XLEN  combinational ALU result
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts response
rsp_id  out  1  requester that owns the response
rsp_result  out  XLEN  captured result
rsp_illegal  out  1  funct code not a supported RV32I ALU op

Behaviour:
- Reset (async, rst_n low): state=IDLE; all outputs 0 (alu_ctrl=4'b0000, alu_a/alu_b=0, rsp_*=0, req_ready_*=0); last_grant=1, so req 0 wins the first tie.
- States: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - req_ready_x is combinational: high only for the granted requester, only in IDLE.
  - Grant: only one valid -> that one; both valid -> the one != last_grant.
  - On handshake: register alu_a/alu_b/alu_ctrl/illegal/id; update last_grant; go to EXEC.
- EXEC (exactly 1 cycle):
  - alu_valid=1.
  - At the clock edge: rsp_result <= alu_result (or 0 if illegal); rsp_valid <= 1; go to RESP.
- RESP:
  - rsp_valid held with rsp_id/rsp_result/rsp_illegal stable until rsp_ready.
  - On rsp_valid & rsp_ready: rsp_valid -> 0; go to IDLE.
  - No new grant in the same cycle; max throughput is 1 op per 3 cycles.
  - Fixed latency: handshake edge -> rsp_valid high 2 cycles later.
- alu_a/alu_b/alu_ctrl hold their last values outside EXEC; alu_valid=0.
- Decode, with f7=funct[10], f3=funct[9:7], op=funct[6:0]:
  - op=0110011 (R): f7=0 -> ctrl={0,f3} for any f3. f7=1 and f3=000 -> SUB 1000. f7=1 and f3=101 -> SRA 1101. Other f7=1 -> illegal.
  - op=0010011 (I): f3 not in {001,101} -> ctrl={0,f3}, f7 ignored. f3=001 -> SLLI 0001, illegal if f7=1. f3=101 -> {f7,101}, i.e. SRLI 0101 / SRAI 1101.
  - SLTIU: I-type f3=011 -> 0011. Distinct from SLT 0010.
  - Any other opcode -> illegal.
- Illegal ops:
  - alu_ctrl=0000 and alu_a/alu_b=0 during EXEC.
  - rsp_result=0, rsp_illegal=1.
  - Same latency as a legal op.
- Encoding summary: ADD 0000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, OR 0110, AND 0111, SUB 1000, SRA 1101.
- Reset mid-operation: transaction dropped, no response issued; requester must reissue.

Optional Feature:
ALU_ISSUE_PERF_EN
- Defined: adds outputs grant_cnt_0, grant_cnt_1 and illegal_cnt, each CNT_W wide.
  - grant_cnt_x increments on each req handshake for that requester.
  - illegal_cnt increments on each accepted illegal op.
  - All saturate at all-ones; all reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Req0 ADD (funct 0_000_0110011), a=5, b=7, rsp_ready=1 -> EXEC shows alu_ctrl=0000; rsp_valid 2 cycles after handshake with rsp_id=0, rsp_result=12 (from ALU model), rsp_illegal=0.
- Both valid from reset, req0 SUB (1_000_0110011), req1 SRAI (1_101_0010011) -> req0 granted first with ctrl=1000; req1 granted next with ctrl=1101; then req0 re-wins if both are valid again.
- Req1 SLLI with f7=1 (1_001_0010011) -> rsp_illegal=1, rsp_result=0, alu_ctrl=0000 during EXEC, latency 2.
- rsp_ready held 0 for 5 cycles -> rsp_valid/rsp_result stable, both req_ready=0; new grant only in the cycle after rsp_ready=1.
- rst_n pulsed low during EXEC -> all outputs 0 immediately; no response after release; next req0 gets a fresh grant.
- With ALU_ISSUE_PERF_EN, CNT_W=4 and 17 req0 ops -> grant_cnt_0 saturates at 15; illegal_cnt counts only illegal ops.
